// File: rtl/logic_unit_scheduler.sv
// logic_unit_scheduler: round-robin arbiter that shares one combinational
// bitwise logic unit among NREQ requesters. Operands and opcode are held in
// registers for SETTLE cycles so the gate network settles before its output
// is captured into the result register.
module logic_unit_scheduler #(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic [WIDTH-1:0]      lu_a,
  output logic [WIDTH-1:0]      lu_b,
  output logic [2:0]            lu_op,
  input  logic [WIDTH-1:0]      lu_y
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] lu_a_q, lu_a_d;
  logic [WIDTH-1:0] lu_b_q, lu_b_d;
  logic [2:0]       lu_op_q, lu_op_d;

  logic found;
  int   win_idx;

  // Round-robin search: first requesting index at or after ptr, wrapping
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == (int'(ptr_q) + i) % NREQ)) begin
          found   = 1'b1;
          win_idx = j;
        end
      end
    end
  end

  // Next-state logic: latch winner in IDLE, count settle window, capture
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    done_d   = done_q;
    result_d = result_q;
    lu_a_d   = lu_a_q;
    lu_b_d   = lu_b_q;
    lu_op_d  = lu_op_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          for (int j = 0; j < NREQ; j++) begin
            if (j == win_idx) begin
              lu_op_d = op[3*j +: 3];
              lu_a_d  = a[WIDTH*j +: WIDTH];
              lu_b_d  = b[WIDTH*j +: WIDTH];
            end
            grant_d[j] = (j == win_idx);
          end
          win_d   = PW'(win_idx);
          cnt_d   = CW'(SETTLE - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          result_d = lu_y;
          grant_d  = '0;
          for (int j = 0; j < NREQ; j++) begin
            done_d[j] = (j == int'(win_q));
          end
          ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      lu_a_q   <= '0;
      lu_b_q   <= '0;
      lu_op_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      lu_a_q   <= lu_a_d;
      lu_b_q   <= lu_b_d;
      lu_op_q  <= lu_op_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign result = result_q;
  assign lu_a   = lu_a_q;
  assign lu_b   = lu_b_q;
  assign lu_op  = lu_op_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Testbench for logic_unit_scheduler: table-driven single operations,
// hand-written arbitration/reset sequences, a randomized run against a
// transaction-level model, and a SETTLE=1 instance.
module tb_logic_unit_scheduler;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;

  logic [N-1:0]   req, grant, done;
  logic [3*N-1:0] op;
  logic [W*N-1:0] a, b;
  logic [W-1:0]   result, lu_a, lu_b, lu_y;
  logic [2:0]     lu_op;
  logic           busy;

  logic [N-1:0]   req1, grant1, done1;
  logic [3*N-1:0] op1;
  logic [W*N-1:0] a1, b1;
  logic [W-1:0]   result1, lu_a1, lu_b1, lu_y1;
  logic [2:0]     lu_op1;
  logic           busy1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] lu_f(input logic [2:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  assign lu_y  = lu_f(lu_op, lu_a, lu_b);
  assign lu_y1 = lu_f(lu_op1, lu_a1, lu_b1);

  logic_unit_scheduler #(.WIDTH(W), .NREQ(N), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .grant(grant), .done(done), .result(result), .busy(busy),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_y(lu_y)
  );

  logic_unit_scheduler #(.WIDTH(W), .NREQ(N), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .op(op1), .a(a1), .b(b1),
    .grant(grant1), .done(done1), .result(result1), .busy(busy1),
    .lu_a(lu_a1), .lu_b(lu_b1), .lu_op(lu_op1), .lu_y(lu_y1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic set_req(input int i, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    op[3*i +: 3] = o;
    a[W*i +: W]  = x;
    b[W*i +: W]  = y;
    req[i]       = 1'b1;
  endtask

  // Assert reset between edges, check outputs clear at once, release idle.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctrl", {grant, done, busy, lu_op}, 32'd0);
    chk("rst_data", {result, lu_a, lu_b}, 32'd0);
    chk("rst_ctrl_s1", {grant1, done1, busy1}, 32'd0);
    req  = '0;
    req1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_idle", {busy, grant, done}, 32'd0);
  endtask

  // Wait for a grant, check it through to done, drop the winner's request.
  task automatic serve(output int wi, output int gc);
    int ok;
    int w;
    logic [N-1:0] g;
    wi = 0;
    gc = 0;
    ok = 0;
    for (int t = 0; t < 40 && ok == 0; t++) begin
      @(negedge clk);
      if (grant != '0) ok = 1;
    end
    chk("grant_seen", ok, 32'd1);
    if (ok != 0) begin
      g  = grant;
      gc = cyc;
      for (int j = 0; j < N; j++) if (g[j]) wi = j;
      chk("grant_onehot", g, N'(1) << wi);
      chk("lu_op", lu_op, op[3*wi +: 3]);
      chk("lu_a", lu_a, a[W*wi +: W]);
      chk("lu_b", lu_b, b[W*wi +: W]);
      w = 0;
      while (grant == g && w < 20) begin
        w++;
        @(negedge clk);
      end
      chk("grant_width", w, ST);
      chk("done", done, g);
      chk("result", result, lu_f(op[3*wi +: 3], a[W*wi +: W], b[W*wi +: W]));
      req[wi] = 1'b0;
      @(negedge clk);
      chk("done_clear", {grant, done}, 32'd0);
    end
  endtask

  typedef struct {
    int         idx;
    logic [2:0] o;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] nand_exp[4];

  initial begin
    int wi, gc, prev_gc, ok, mw, mptr, free_at, gcyc, inflight, dropped;
    logic [N-1:0] dseen;
    logic [W-1:0] exp_res, cur;

    tbl[0] = '{2, 3'd2, 8'hA5, 8'h0F, 8'hAA};
    tbl[1] = '{0, 3'd0, 8'hF0, 8'h3C, 8'h30};
    tbl[2] = '{1, 3'd1, 8'hF0, 8'h0C, 8'hFC};
    tbl[3] = '{3, 3'd3, 8'hFF, 8'h0F, 8'hF0};
    tbl[4] = '{1, 3'd4, 8'h50, 8'h05, 8'hAA};
    tbl[5] = '{2, 3'd5, 8'h33, 8'h0F, 8'hC3};
    tbl[6] = '{0, 3'd6, 8'h5A, 8'h00, 8'hA5};
    tbl[7] = '{3, 3'd7, 8'h81, 8'hFF, 8'h81};
    nand_exp[0] = 8'hFF; nand_exp[1] = 8'hFE; nand_exp[2] = 8'hFD; nand_exp[3] = 8'hFC;

    req = '0; op = '0; a = '0; b = '0;
    req1 = '0; op1 = '0; a1 = '0; b1 = '0;
    do_reset();

    // Table of single operations covering every opcode
    for (int k = 0; k < 8; k++) begin
      set_req(tbl[k].idx, tbl[k].o, tbl[k].x, tbl[k].y);
      serve(wi, gc);
      chk("tbl_winner", wi, tbl[k].idx);
      chk("tbl_result", result, {24'd0, tbl[k].r});
    end

    // All four at once from ptr=0: NAND with a=FF, b=i
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'd3, 8'hFF, W'(i));
    prev_gc = 0;
    for (int k = 0; k < N; k++) begin
      serve(wi, gc);
      chk("all4_order", wi, k);
      chk("all4_result", result, {24'd0, nand_exp[k]});
      if (k > 0) chk("all4_spacing", gc - prev_gc, ST + 2);
      prev_gc = gc;
    end

    // Fairness: requesters 0 and 3 re-request after each completion
    set_req(0, 3'd2, 8'h11, 8'h22);
    set_req(3, 3'd1, 8'h44, 8'h08);
    for (int k = 0; k < 8; k++) begin
      serve(wi, gc);
      chk("fair_order", wi, (k % 2 == 0) ? 0 : 3);
      if (k < 7) req[wi] = 1'b1;
    end
    serve(wi, gc);
    chk("fair_drain", wi, 0);

    // Withdrawal during WAIT still completes
    set_req(1, 3'd1, 8'h12, 8'h40);
    ok = 0;
    for (int t = 0; t < 20 && ok == 0; t++) begin
      @(negedge clk);
      if (grant != '0) ok = 1;
    end
    chk("wd_grant", grant, 32'b0010);
    @(negedge clk);
    req[1] = 1'b0;
    ok = 0;
    for (int t = 0; t < 10 && ok == 0; t++) begin
      @(negedge clk);
      if (done != '0) ok = 1;
    end
    chk("wd_done", done, 32'b0010);
    chk("wd_result", result, 32'h52);
    @(negedge clk);

    // Reset in the second WAIT cycle aborts the operation
    set_req(3, 3'd2, 8'h3C, 8'h0F);
    ok = 0;
    for (int t = 0; t < 20 && ok == 0; t++) begin
      @(negedge clk);
      if (grant != '0) ok = 1;
    end
    chk("mid_grant", grant, 32'b1000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {grant, done, busy, lu_op}, 32'd0);
    chk("mid_rst_data", {result, lu_a, lu_b}, 32'd0);
    req[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dseen = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      dseen = dseen | done;
    end
    chk("mid_no_done", dseen, 32'd0);
    chk("mid_result", result, 32'd0);
    set_req(1, 3'd0, 8'hF0, 8'hAA);
    set_req(3, 3'd5, 8'h0F, 8'h0F);
    serve(wi, gc);
    chk("mid_ptr0", wi, 1);
    serve(wi, gc);
    chk("mid_next", wi, 3);

    // Randomized traffic against a transaction-level model
    do_reset();
    inflight = 0; mptr = 0; free_at = 0; gcyc = 0; mw = 0; exp_res = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      dropped = -1;
      if (inflight != 0) begin
        if (cyc == gcyc + ST) begin
          chk("rnd_done", {grant, done}, {N'(0), N'(1) << mw});
          chk("rnd_result", result, exp_res);
          inflight = 0;
          free_at  = cyc + 2;
          mptr     = (mw + 1) % N;
          req[mw]  = 1'b0;
          dropped  = mw;
        end else begin
          chk("rnd_hold", {grant, done}, {N'(1) << mw, N'(0)});
        end
      end else if (cyc >= free_at && req != '0) begin
        mw = -1;
        for (int k = 0; k < N; k++) begin
          if (mw < 0 && req[(mptr + k) % N]) mw = (mptr + k) % N;
        end
        chk("rnd_grant", {grant, done}, {N'(1) << mw, N'(0)});
        chk("rnd_lu", {lu_op, lu_a, lu_b}, {op[3*mw +: 3], a[W*mw +: W], b[W*mw +: W]});
        exp_res  = lu_f(op[3*mw +: 3], a[W*mw +: W], b[W*mw +: W]);
        inflight = 1;
        gcyc     = cyc;
      end else begin
        chk("rnd_idle", {grant, done}, 32'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && i != dropped && $urandom_range(0, 3) == 0)
          set_req(i, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      end
    end

    // SETTLE=1 instance: back-to-back NOR from one requester
    do_reset();
    op1[2:0] = 3'd4;
    a1[W-1:0] = 8'h0F;
    b1[W-1:0] = 8'h30;
    req1[0] = 1'b1;
    ok = 0;
    for (int t = 0; t < 10 && ok == 0; t++) begin
      @(negedge clk);
      if (grant1 != '0) ok = 1;
    end
    chk("s1_grant_seen", ok, 32'd1);
    cur = '0;
    for (int p = 0; p < 9; p++) begin
      if (p > 0) @(negedge clk);
      chk("s1_pattern", {grant1, done1},
          {(p % 3 == 0) ? N'(1) : N'(0), (p % 3 == 1) ? N'(1) : N'(0)});
      if (p % 3 == 0) cur = ~(a1[W-1:0] | b1[W-1:0]);
      if (p % 3 == 1) begin
        chk("s1_result", result1, cur);
        a1[W-1:0] = a1[W-1:0] + 8'h11;
      end
    end
    req1 = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
